// File: rtl/sif_arb_pkg.sv
// Shared types and constants for the SIF X-side access arbiter.
package sif_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } arb_state_e;

  typedef logic req_id_t;

  localparam int unsigned SIF_ARB_CNT_W = 16;

  localparam int unsigned RD_LAT_MIN   = 1;
  localparam int unsigned RD_LAT_MAX   = 15;
  localparam int unsigned RD_LAT_CNT_W = 4;

endpackage

// File: rtl/sif_arb_rr.sv
// Combinational two-way round-robin picker: on contention the requester that did not win last wins.
module sif_arb_rr
  import sif_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  output logic       valid,
  output req_id_t    id
);

  always_comb begin
    valid = |req;
    if (&req) begin
      id = ~last;
    end else begin
      id = req[1];
    end
  end

endmodule

// File: rtl/sif_xa_arbiter.sv
// Two-requester round-robin arbiter sharing the SIF X-side access port.
// Define SIF_ARB_STATS_EN to add saturating per-requester ack counters (r0_cnt / r1_cnt).
module sif_xa_arbiter
  import sif_arb_pkg::*;
#(
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     r0_req,
  input  logic                     r0_wr,
  input  logic [AW-1:0]            r0_addr,
  input  logic [DW-1:0]            r0_data_wr,
  input  logic                     r1_req,
  input  logic                     r1_wr,
  input  logic [AW-1:0]            r1_addr,
  input  logic [DW-1:0]            r1_data_wr,
  output logic                     r0_ack,
  output logic [DW-1:0]            r0_data_rd,
  output logic                     r1_ack,
  output logic [DW-1:0]            r1_data_rd,
  output logic [AW-1:0]            xa_addr,
  output logic [DW-1:0]            xa_data_wr,
  output logic                     xa_wr_s,
  output logic                     xa_rd_s,
  input  logic [DW-1:0]            xa_data_rd,
`ifdef SIF_ARB_STATS_EN
  output logic [SIF_ARB_CNT_W-1:0] r0_cnt,
  output logic [SIF_ARB_CNT_W-1:0] r1_cnt,
`endif
  output logic                     busy,
  output logic                     gnt_id
);

  localparam int unsigned RdLat = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                                  (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam logic [RD_LAT_CNT_W-1:0] RdCntLoad = RD_LAT_CNT_W'(RdLat - 1);
  localparam logic [RD_LAT_CNT_W-1:0] RdCntOne  = RD_LAT_CNT_W'(1);

  arb_state_e              state_q, state_d;
  req_id_t                 last_q, last_d;
  req_id_t                 gnt_id_q, gnt_id_d;
  logic                    wr_q, wr_d;
  logic [RD_LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]           xa_addr_q, xa_addr_d;
  logic [DW-1:0]           xa_data_wr_q, xa_data_wr_d;
  logic                    xa_wr_s_q, xa_wr_s_d;
  logic                    xa_rd_s_q, xa_rd_s_d;
  logic                    busy_q, busy_d;
  logic                    r0_ack_q, r0_ack_d;
  logic                    r1_ack_q, r1_ack_d;
  logic [DW-1:0]           r0_data_rd_q, r0_data_rd_d;
  logic [DW-1:0]           r1_data_rd_q, r1_data_rd_d;

  logic    pick_valid;
  req_id_t pick_id;
  logic    pick_wr;

  sif_arb_rr u_rr (
    .req   ({r1_req, r0_req}),
    .last  (last_q),
    .valid (pick_valid),
    .id    (pick_id)
  );

  assign pick_wr = pick_id ? r1_wr : r0_wr;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gnt_id_d     = gnt_id_q;
    wr_d         = wr_q;
    cnt_d        = cnt_q;
    xa_addr_d    = xa_addr_q;
    xa_data_wr_d = xa_data_wr_q;
    xa_wr_s_d    = 1'b0;
    xa_rd_s_d    = 1'b0;
    r0_ack_d     = 1'b0;
    r1_ack_d     = 1'b0;
    r0_data_rd_d = r0_data_rd_q;
    r1_data_rd_d = r1_data_rd_q;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_id_d     = pick_id;
          wr_d         = pick_wr;
          xa_addr_d    = pick_id ? r1_addr : r0_addr;
          xa_data_wr_d = pick_id ? r1_data_wr : r0_data_wr;
          xa_wr_s_d    = pick_wr;
          xa_rd_s_d    = ~pick_wr;
          // A write completes in the strobe cycle, so its ack rises with the strobe.
          if (pick_wr) begin
            r0_ack_d = ~pick_id;
            r1_ack_d = pick_id;
            last_d   = pick_id;
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (wr_q) begin
          state_d = StIdle;
        end else if (RdCntLoad == '0) begin
          // Single-cycle latency: read data is already valid at the end of the strobe cycle.
          r0_data_rd_d = gnt_id_q ? r0_data_rd_q : xa_data_rd;
          r1_data_rd_d = gnt_id_q ? xa_data_rd : r1_data_rd_q;
          r0_ack_d     = ~gnt_id_q;
          r1_ack_d     = gnt_id_q;
          last_d       = gnt_id_q;
          state_d      = StDone;
        end else begin
          cnt_d   = RdCntLoad;
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - RdCntOne;
        if (cnt_d == '0) begin
          r0_data_rd_d = gnt_id_q ? r0_data_rd_q : xa_data_rd;
          r1_data_rd_d = gnt_id_q ? xa_data_rd : r1_data_rd_q;
          r0_ack_d     = ~gnt_id_q;
          r1_ack_d     = gnt_id_q;
          last_d       = gnt_id_q;
          state_d      = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_q       <= 1'b1;
      gnt_id_q     <= 1'b0;
      wr_q         <= 1'b0;
      cnt_q        <= '0;
      xa_addr_q    <= '0;
      xa_data_wr_q <= '0;
      xa_wr_s_q    <= 1'b0;
      xa_rd_s_q    <= 1'b0;
      busy_q       <= 1'b0;
      r0_ack_q     <= 1'b0;
      r1_ack_q     <= 1'b0;
      r0_data_rd_q <= '0;
      r1_data_rd_q <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      gnt_id_q     <= gnt_id_d;
      wr_q         <= wr_d;
      cnt_q        <= cnt_d;
      xa_addr_q    <= xa_addr_d;
      xa_data_wr_q <= xa_data_wr_d;
      xa_wr_s_q    <= xa_wr_s_d;
      xa_rd_s_q    <= xa_rd_s_d;
      busy_q       <= busy_d;
      r0_ack_q     <= r0_ack_d;
      r1_ack_q     <= r1_ack_d;
      r0_data_rd_q <= r0_data_rd_d;
      r1_data_rd_q <= r1_data_rd_d;
    end
  end

  assign xa_addr    = xa_addr_q;
  assign xa_data_wr = xa_data_wr_q;
  assign xa_wr_s    = xa_wr_s_q;
  assign xa_rd_s    = xa_rd_s_q;
  assign busy       = busy_q;
  assign gnt_id     = gnt_id_q;
  assign r0_ack     = r0_ack_q;
  assign r1_ack     = r1_ack_q;
  assign r0_data_rd = r0_data_rd_q;
  assign r1_data_rd = r1_data_rd_q;

`ifdef SIF_ARB_STATS_EN
  logic [SIF_ARB_CNT_W-1:0] r0_cnt_q, r0_cnt_d;
  logic [SIF_ARB_CNT_W-1:0] r1_cnt_q, r1_cnt_d;

  always_comb begin
    r0_cnt_d = r0_cnt_q;
    r1_cnt_d = r1_cnt_q;
    if (r0_ack_q && (r0_cnt_q != '1)) r0_cnt_d = r0_cnt_q + SIF_ARB_CNT_W'(1);
    if (r1_ack_q && (r1_cnt_q != '1)) r1_cnt_d = r1_cnt_q + SIF_ARB_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_cnt_q <= '0;
      r1_cnt_q <= '0;
    end else begin
      r0_cnt_q <= r0_cnt_d;
      r1_cnt_q <= r1_cnt_d;
    end
  end

  assign r0_cnt = r0_cnt_q;
  assign r1_cnt = r1_cnt_q;
`endif

endmodule

// File: tb/tb_sif_xa_arbiter.sv
// Directed self-checking bench for sif_xa_arbiter (RD_LAT = 3).
module tb_sif_xa_arbiter;

  localparam int unsigned AW     = 16;
  localparam int unsigned DW     = 16;
  localparam int unsigned RD_LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          r0_req, r0_wr, r1_req, r1_wr;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_data_wr, r1_data_wr;
  logic          r0_ack, r1_ack;
  logic [DW-1:0] r0_data_rd, r1_data_rd;
  logic [AW-1:0] xa_addr;
  logic [DW-1:0] xa_data_wr;
  logic          xa_wr_s, xa_rd_s;
  logic [DW-1:0] xa_data_rd;
  logic          busy, gnt_id;
`ifdef SIF_ARB_STATS_EN
  logic [15:0]   r0_cnt, r1_cnt;
`endif

  int n_checks = 0;
  int n_passed = 0;

  always #5 clk = ~clk;

  sif_xa_arbiter #(
    .AW     (AW),
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .r0_req     (r0_req),
    .r0_wr      (r0_wr),
    .r0_addr    (r0_addr),
    .r0_data_wr (r0_data_wr),
    .r1_req     (r1_req),
    .r1_wr      (r1_wr),
    .r1_addr    (r1_addr),
    .r1_data_wr (r1_data_wr),
    .r0_ack     (r0_ack),
    .r0_data_rd (r0_data_rd),
    .r1_ack     (r1_ack),
    .r1_data_rd (r1_data_rd),
    .xa_addr    (xa_addr),
    .xa_data_wr (xa_data_wr),
    .xa_wr_s    (xa_wr_s),
    .xa_rd_s    (xa_rd_s),
    .xa_data_rd (xa_data_rd),
`ifdef SIF_ARB_STATS_EN
    .r0_cnt     (r0_cnt),
    .r1_cnt     (r1_cnt),
`endif
    .busy       (busy),
    .gnt_id     (gnt_id)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic id, input logic wr, input logic [15:0] addr,
                           input logic [15:0] data);
    if (id) begin
      r1_req = 1'b1; r1_wr = wr; r1_addr = addr; r1_data_wr = data;
    end else begin
      r0_req = 1'b1; r0_wr = wr; r0_addr = addr; r0_data_wr = data;
    end
  endtask

  task automatic drop_req(input logic id);
    if (id) r1_req = 1'b0;
    else    r0_req = 1'b0;
  endtask

  task automatic write_access(input logic id, input logic [15:0] addr, input logic [15:0] data);
    drive_req(id, 1'b1, addr, data);
    step();
    check_eq("wr_strobe", xa_wr_s, 1);
    check_eq("wr_no_rd_strobe", xa_rd_s, 0);
    check_eq("wr_addr", xa_addr, addr);
    check_eq("wr_data", xa_data_wr, data);
    check_eq("wr_gnt_id", gnt_id, id);
    check_eq("wr_ack", id ? r1_ack : r0_ack, 1);
    check_eq("wr_ack_other", id ? r0_ack : r1_ack, 0);
    check_eq("wr_busy", busy, 1);
    step();
    drop_req(id);
    check_eq("wr_strobe_end", xa_wr_s, 0);
    check_eq("wr_ack_end", id ? r1_ack : r0_ack, 0);
    check_eq("wr_idle", busy, 0);
    check_eq("wr_addr_hold", xa_addr, addr);
  endtask

  task automatic read_access(input logic id, input logic [15:0] addr, input logic [15:0] rdata);
    drive_req(id, 1'b0, addr, 16'h0000);
    step();
    check_eq("rd_strobe", xa_rd_s, 1);
    check_eq("rd_no_wr_strobe", xa_wr_s, 0);
    check_eq("rd_addr", xa_addr, addr);
    check_eq("rd_gnt_id", gnt_id, id);
    for (int k = 2; k <= int'(RD_LAT); k++) begin
      step();
      check_eq("rd_wait_strobe", xa_rd_s, 0);
      check_eq("rd_wait_no_ack", id ? r1_ack : r0_ack, 0);
      if (k == int'(RD_LAT)) xa_data_rd = rdata;
    end
    step();
    xa_data_rd = 16'hDEAD;
    check_eq("rd_ack", id ? r1_ack : r0_ack, 1);
    check_eq("rd_data", id ? r1_data_rd : r0_data_rd, rdata);
    check_eq("rd_busy_done", busy, 1);
    drop_req(id);
    step();
    check_eq("rd_ack_end", id ? r1_ack : r0_ack, 0);
    check_eq("rd_idle", busy, 0);
    check_eq("rd_data_hold", id ? r1_data_rd : r0_data_rd, rdata);
  endtask

  // Strobe exclusivity is checked on every falling edge outside reset.
  always @(negedge clk) begin
    if (rst_n) check_eq("strobe_excl", {31'b0, xa_wr_s & xa_rd_s}, 0);
  end

  initial begin
    rst_n = 1'b0;
    r0_req = 1'b0; r0_wr = 1'b0; r0_addr = '0; r0_data_wr = '0;
    r1_req = 1'b0; r1_wr = 1'b0; r1_addr = '0; r1_data_wr = '0;
    xa_data_rd = 16'hDEAD;
    #2;
    check_eq("rst_addr", xa_addr, 0);
    check_eq("rst_data_wr", xa_data_wr, 0);
    check_eq("rst_strobes", {xa_wr_s, xa_rd_s}, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_gnt_id", gnt_id, 0);
    check_eq("rst_acks", {r0_ack, r1_ack}, 0);
    check_eq("rst_data_rd", {r0_data_rd, r1_data_rd}, 0);
    step();
    rst_n = 1'b1;
    step();

    // Single write then single read.
    write_access(1'b0, 16'h0010, 16'hA5A5);
    read_access(1'b1, 16'h0020, 16'h1234);

    // Contention out of reset: both hold writes, grants must alternate starting with r0.
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive_req(1'b0, 1'b1, 16'h0100, 16'h1111);
    drive_req(1'b1, 1'b1, 16'h0200, 16'h2222);
    for (int i = 0; i < 8; i++) begin
      logic exp_id;
      exp_id = logic'(i % 2);
      step();
      check_eq("cont_strobe", xa_wr_s, 1);
      check_eq("cont_gnt_id", gnt_id, exp_id);
      check_eq("cont_addr", xa_addr, exp_id ? 16'h0200 : 16'h0100);
      check_eq("cont_data", xa_data_wr, exp_id ? 16'h2222 : 16'h1111);
      check_eq("cont_acks", {r1_ack, r0_ack}, exp_id ? 2'b10 : 2'b01);
      if (i == 7) begin
        drop_req(1'b0);
        drop_req(1'b1);
      end
      step();
      check_eq("cont_gap", {xa_wr_s, r0_ack, r1_ack}, 0);
    end

    // Mixed: r1 write arrives while r0 read sits in the latency window.
    drive_req(1'b0, 1'b0, 16'h0300, 16'h0000);
    step();
    check_eq("mix_rd_strobe", xa_rd_s, 1);
    check_eq("mix_rd_gnt", gnt_id, 0);
    drive_req(1'b1, 1'b1, 16'h0400, 16'hBEEF);
    step();
    check_eq("mix_wait1_strobes", {xa_wr_s, xa_rd_s}, 0);
    check_eq("mix_wait1_r1_ack", r1_ack, 0);
    step();
    xa_data_rd = 16'h5678;
    check_eq("mix_wait2_strobes", {xa_wr_s, xa_rd_s}, 0);
    step();
    xa_data_rd = 16'hDEAD;
    check_eq("mix_r0_ack", r0_ack, 1);
    check_eq("mix_r0_data", r0_data_rd, 16'h5678);
    check_eq("mix_no_wr_yet", {xa_wr_s, r1_ack}, 0);
    drop_req(1'b0);
    step();
    check_eq("mix_idle_gap", {xa_wr_s, busy}, 0);
    step();
    check_eq("mix_wr_strobe", xa_wr_s, 1);
    check_eq("mix_wr_addr", xa_addr, 16'h0400);
    check_eq("mix_wr_data", xa_data_wr, 16'hBEEF);
    check_eq("mix_wr_ack", r1_ack, 1);
    check_eq("mix_wr_gnt", gnt_id, 1);
    drop_req(1'b1);
    step();
    check_eq("mix_end_idle", {xa_wr_s, r1_ack, busy}, 0);

    // Reset during the read latency window.
    drive_req(1'b1, 1'b0, 16'h0500, 16'h0000);
    step();
    check_eq("rstrd_strobe", xa_rd_s, 1);
    step();
    check_eq("rstrd_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstrd_strobes", {xa_wr_s, xa_rd_s}, 0);
    check_eq("rstrd_busy_clr", busy, 0);
    check_eq("rstrd_addr_clr", xa_addr, 0);
    check_eq("rstrd_gnt_clr", gnt_id, 0);
    check_eq("rstrd_data_clr", {r0_data_rd, r1_data_rd}, 0);
    drop_req(1'b1);
    xa_data_rd = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rstrd_no_ack", {r0_ack, r1_ack, busy}, 0);
    end
    xa_data_rd = 16'hDEAD;
    rst_n = 1'b1;
    step();
    check_eq("rstrd_no_late_ack", {r0_ack, r1_ack}, 0);
    write_access(1'b0, 16'h0600, 16'h0F0F);

`ifdef SIF_ARB_STATS_EN
    write_access(1'b0, 16'h0700, 16'h0001);
    write_access(1'b0, 16'h0701, 16'h0002);
    for (int i = 0; i < 5; i++) write_access(1'b1, 16'h0800, 16'h0003);
    check_eq("stats_r0_cnt", r0_cnt, 3);
    check_eq("stats_r1_cnt", r1_cnt, 5);
`endif

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
